ask4_upsampler: RTL

ASK4_UPSAMPLER -- requirements
Module: ask4_upsampler

---
 rtl/ask4_pkg.sv | 38 +++
 rtl/sym_fifo2.sv | 49 ++++
 rtl/ask4_upsampler.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/ask4_pkg.sv
// Shared types and the 4-ASK level mapping for the ask4_upsampler slice.
package ask4_pkg;

  typedef logic [1:0]         sym_t;
  typedef logic signed [17:0] sample_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic signed [19:0] SAMPLE_MAX = 20'sd131071;
  localparam logic signed [19:0] SAMPLE_MIN = -20'sd131072;

  // Gray code keeps adjacent levels one bit apart; the product is formed at 20 bits so
  // an oversized AMP clips to full scale instead of wrapping.
  function automatic sample_t map_level(input sym_t sym, input sample_t amp);
    logic signed [19:0] amp_w;
    logic signed [19:0] coef;
    logic signed [19:0] prod;
    amp_w = 20'(amp);
    case (sym)
      2'b00:   coef = -20'sd3;
      2'b01:   coef = -20'sd1;
      2'b11:   coef = 20'sd1;
      default: coef = 20'sd3;
    endcase
    prod = amp_w * coef;
    if (prod > SAMPLE_MAX) begin
      map_level = 18'sd131071;
    end else if (prod < SAMPLE_MIN) begin
      map_level = -18'sd131072;
    end else begin
      map_level = prod[17:0];
    end
  endfunction

endpackage

// File: rtl/sym_fifo2.sv
// Two-entry symbol FIFO; a pop in the same cycle frees the slot for a push when full.
module sym_fifo2
  import ask4_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  sym_t din,
  input  logic pop,
  output sym_t dout,
  output logic full,
  output logic empty
);

  sym_t       mem [2];
  logic       wptr;
  logic       rptr;
  logic [1:0] count;
  logic       do_push;
  logic       do_pop;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rptr];
  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (do_push) wptr <= ~wptr;
      if (do_pop)  rptr <= ~rptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the pointers and count decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/ask4_upsampler.sv
// 4-ASK symbol mapper with zero-stuffing upsample by SPS.
// Define ASK4_PRBS_EN to source symbols from an internal PRBS-15 instead of sym_in.
module ask4_upsampler
  import ask4_pkg::*;
#(
  parameter int             SPS = 4,
  parameter logic signed [17:0] AMP = 18'sd32768
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         sym_in,
  input  logic               sym_valid,
  output logic               sym_ready,
  output logic signed [17:0] x_out,
  output logic               sym_strobe,
  output logic               underflow
);

  localparam int PW = (SPS > 1) ? $clog2(SPS) : 1;

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] phase;
  logic [PW-1:0] phase_nxt;
  logic          ready_en;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  sym_t          din;
  sym_t          dout;

  // Holds the input side closed until the first edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

`ifdef ASK4_PRBS_EN
  localparam logic [14:0] PRBS_SEED = 15'h0001;
  localparam logic        UF_EN     = 1'b0;

  logic [14:0] lfsr;
  logic [14:0] lfsr_mid;
  logic [14:0] lfsr_nxt;
  logic        bit_a;
  logic        bit_b;

  // x^15 + x^14 + 1, stepped twice per symbol; the first bit generated is the symbol MSB.
  always_comb begin
    bit_a    = lfsr[14] ^ lfsr[13];
    lfsr_mid = {lfsr[13:0], bit_a};
    bit_b    = lfsr_mid[14] ^ lfsr_mid[13];
    lfsr_nxt = {lfsr_mid[13:0], bit_b};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    lfsr <= PRBS_SEED;
    else if (push) lfsr <= lfsr_nxt;
  end

  assign sym_ready = 1'b0;
  assign push      = ready_en & (~full | pop);
  assign din       = {bit_a, bit_b};
`else
  localparam logic UF_EN = 1'b1;

  assign sym_ready = ready_en & (~full | pop);
  assign push      = sym_valid & sym_ready;
  assign din       = sym_in;
`endif

  sym_fifo2 u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .dout  (dout),
    .full  (full),
    .empty (empty)
  );

  assign pop = (state == RUN) && (phase == '0) && !empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      phase <= '0;
    end else begin
      state <= state_nxt;
      phase <= phase_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    case (state)
      IDLE: begin
        phase_nxt = '0;
        if (!empty) state_nxt = RUN;
      end
      RUN: begin
        if ((phase == '0) && empty) begin
          state_nxt = IDLE;
          phase_nxt = '0;
        end else if (phase == PW'(SPS - 1)) begin
          phase_nxt = '0;
        end else begin
          phase_nxt = phase + PW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        phase_nxt = '0;
      end
    endcase
  end

  // Every non-symbol cycle emits a stuffed zero; a phase-0 slot with nothing queued flags underflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_out      <= '0;
      sym_strobe <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      x_out      <= '0;
      sym_strobe <= 1'b0;
      underflow  <= 1'b0;
      if (pop) begin
        x_out      <= map_level(dout, AMP);
        sym_strobe <= 1'b1;
      end else if ((state == RUN) && (phase == '0)) begin
        underflow <= UF_EN;
      end
    end
  end

endmodule
